// File: rtl/dest_ip_tbl_ctrl_if.sv
// AXI4-Lite slave bundle for the dest-IP table controller register front end.
interface dest_ip_tbl_ctrl_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/dest_ip_tbl_ctrl.sv
// AXI4-Lite command/status front end sequencing req/ack accesses to the dest-IP filter table.
module dest_ip_tbl_ctrl #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int TBL_ADDR_WIDTH     = 5,
   parameter int ACK_TIMEOUT        = 16
) (
   input  logic                          AXI_ACLK,
   input  logic                          reset,
   dest_ip_tbl_ctrl_if.slave             s_axi,
   output logic                          tbl_wr_req,
   output logic                          tbl_rd_req,
   output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
   output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
   input  logic                          tbl_wr_ack,
   input  logic                          tbl_rd_ack
);
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, WAIT_ACK} state_t;
   state_t state, state_nxt;

   logic                          awready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]                    bresp_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_mux;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_data_reg, rd_data_reg, cap_data;
   logic [TBL_ADDR_WIDTH-1:0]     addr_reg, cap_addr;
   logic                          done, timeout, op_rd;
   logic [CNT_W-1:0]              ack_cnt;
   logic [2:0]                    aw_idx, ar_idx;
   logic                          aw_hs, ar_hs, busy, cmd_hit, cmd_wr, cmd_rd, ack_ok, to_hit;
   logic                          unused_ok;

   assign aw_idx  = s_axi.S_AXI_AWADDR[4:2];
   assign ar_idx  = s_axi.S_AXI_ARADDR[4:2];
   assign aw_hs   = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
   assign ar_hs   = arready_q & s_axi.S_AXI_ARVALID;
   assign busy    = (state != IDLE);
   assign cmd_hit = aw_hs & (aw_idx == 3'd2) & ~busy;
   assign cmd_wr  = cmd_hit & (s_axi.S_AXI_WDATA == C_S_AXI_DATA_WIDTH'(1));
   assign cmd_rd  = cmd_hit & (s_axi.S_AXI_WDATA == C_S_AXI_DATA_WIDTH'(2));
   assign ack_ok  = op_rd ? tbl_rd_ack : tbl_wr_ack;
   assign to_hit  = (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = awready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = 2'b00;

   // Table outputs come from values captured at command issue, not the live staging registers.
   assign tbl_wr_addr = cap_addr;
   assign tbl_rd_addr = cap_addr;
   assign tbl_wr_data = cap_data;

   assign unused_ok = ^{s_axi.S_AXI_WSTRB,
                        s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:5], s_axi.S_AXI_AWADDR[1:0],
                        s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:5], s_axi.S_AXI_ARADDR[1:0]};

   always_ff @(posedge AXI_ACLK) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      tbl_wr_req = 1'b0;
      tbl_rd_req = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_wr)      state_nxt = WR_REQ;
            else if (cmd_rd) state_nxt = RD_REQ;
         end
         WR_REQ: begin
            tbl_wr_req = 1'b1;
            state_nxt  = WAIT_ACK;
         end
         RD_REQ: begin
            tbl_rd_req = 1'b1;
            state_nxt  = WAIT_ACK;
         end
         WAIT_ACK: if (ack_ok || to_hit) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (ar_idx)
         3'd0:    rd_mux = wr_data_reg;
         3'd1:    rd_mux[TBL_ADDR_WIDTH-1:0] = addr_reg;
         3'd3:    rd_mux = rd_data_reg;
         3'd4:    rd_mux[2:0] = {timeout, done, busy};
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         awready_q   <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         wr_data_reg <= '0;
         addr_reg    <= '0;
         rd_data_reg <= '0;
         cap_addr    <= '0;
         cap_data    <= '0;
         op_rd       <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         ack_cnt     <= '0;
      end else begin
         awready_q <= s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~awready_q;
         if (aw_hs) begin
            bvalid_q <= 1'b1;
            bresp_q  <= ((aw_idx == 3'd2) && busy) ? 2'b10 : 2'b00;
            case (aw_idx)
               3'd0:    wr_data_reg <= s_axi.S_AXI_WDATA;
               3'd1:    addr_reg    <= s_axi.S_AXI_WDATA[TBL_ADDR_WIDTH-1:0];
               default: ;
            endcase
         end else if (s_axi.S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
         end

         arready_q <= s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
         end else if (s_axi.S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
         end

         if (cmd_wr || cmd_rd) begin
            cap_addr <= addr_reg;
            op_rd    <= cmd_rd;
            done     <= 1'b0;
            timeout  <= 1'b0;
         end
         if (cmd_wr) cap_data <= wr_data_reg;

         if (state == WAIT_ACK) begin
            if (ack_ok) begin
               done <= 1'b1;
               if (op_rd) rd_data_reg <= tbl_rd_data;
            end else if (to_hit) begin
               done    <= 1'b1;
               timeout <= 1'b1;
            end else begin
               ack_cnt <= ack_cnt + 1'b1;
            end
         end else begin
            ack_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_dest_ip_tbl_ctrl.sv
// Directed self-checking bench for dest_ip_tbl_ctrl with a behavioural table responder.
module tb_dest_ip_tbl_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dest_ip_tbl_ctrl_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) axi ();

   logic        tbl_wr_req, tbl_rd_req;
   logic [4:0]  tbl_wr_addr, tbl_rd_addr;
   logic [31:0] tbl_wr_data;
   logic [31:0] tbl_rd_data = '0;
   logic        tbl_wr_ack = 1'b0;
   logic        tbl_rd_ack = 1'b0;

   dest_ip_tbl_ctrl #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(32),
      .TBL_ADDR_WIDTH(5),
      .ACK_TIMEOUT(16)
   ) dut (
      .AXI_ACLK(clk),
      .reset(reset),
      .s_axi(axi.slave),
      .tbl_wr_req(tbl_wr_req),
      .tbl_rd_req(tbl_rd_req),
      .tbl_wr_addr(tbl_wr_addr),
      .tbl_rd_addr(tbl_rd_addr),
      .tbl_wr_data(tbl_wr_data),
      .tbl_rd_data(tbl_rd_data),
      .tbl_wr_ack(tbl_wr_ack),
      .tbl_rd_ack(tbl_rd_ack)
   );

   int          checks = 0;
   int          failures = 0;
   logic        req_after_hs;

   // Responder: ack resp_delay cycles after the request (1 = next cycle); counts pulses.
   int          resp_delay = 1;
   bit          resp_en = 1'b1;
   logic [31:0] resp_value = '0;
   int          resp_cnt = 0;
   bit          resp_rd = 1'b0;
   int          wr_pulses = 0;
   int          rd_pulses = 0;
   logic [4:0]  seen_wr_addr = '0;
   logic [4:0]  seen_rd_addr = '0;
   logic [31:0] seen_wr_data = '0;

   always @(posedge clk) begin
      tbl_wr_ack <= 1'b0;
      tbl_rd_ack <= 1'b0;
      if (reset) begin
         resp_cnt <= 0;
      end else begin
         if (tbl_wr_req) begin
            wr_pulses    <= wr_pulses + 1;
            seen_wr_addr <= tbl_wr_addr;
            seen_wr_data <= tbl_wr_data;
         end
         if (tbl_rd_req) begin
            rd_pulses    <= rd_pulses + 1;
            seen_rd_addr <= tbl_rd_addr;
         end
         if ((tbl_wr_req || tbl_rd_req) && resp_en) begin
            if (resp_delay <= 1) begin
               tbl_wr_ack  <= tbl_wr_req;
               tbl_rd_ack  <= tbl_rd_req;
               tbl_rd_data <= resp_value;
            end else begin
               resp_cnt <= resp_delay - 1;
               resp_rd  <= tbl_rd_req;
            end
         end else if (resp_cnt > 0) begin
            resp_cnt <= resp_cnt - 1;
            if (resp_cnt == 1) begin
               tbl_wr_ack  <= !resp_rd;
               tbl_rd_ack  <= resp_rd;
               tbl_rd_data <= resp_value;
            end
         end
      end
   end

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
      int n;
      @(negedge clk);
      axi.S_AXI_AWADDR  = a;
      axi.S_AXI_WDATA   = d;
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WVALID  = 1'b1;
      axi.S_AXI_BREADY  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.S_AXI_AWREADY && n < 20);
      checks++;
      if (!axi.S_AXI_AWREADY) begin
         failures++;
         $display("FAIL aw_handshake addr=%h awready=0 required 1", a);
         axi.S_AXI_AWVALID = 1'b0;
         axi.S_AXI_WVALID  = 1'b0;
         resp = 2'bxx;
         return;
      end
      @(negedge clk);
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      req_after_hs = tbl_wr_req | tbl_rd_req;
      n = 0;
      while (!axi.S_AXI_BVALID && n < 20) begin @(negedge clk); n++; end
      resp = axi.S_AXI_BVALID ? axi.S_AXI_BRESP : 2'bxx;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      @(negedge clk);
      axi.S_AXI_ARADDR  = a;
      axi.S_AXI_ARVALID = 1'b1;
      axi.S_AXI_RREADY  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.S_AXI_ARREADY && n < 20);
      @(negedge clk);
      axi.S_AXI_ARVALID = 1'b0;
      n = 0;
      while (!axi.S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!axi.S_AXI_RVALID) begin
         failures++;
         $display("FAIL r_handshake addr=%h rvalid=0 required 1", a);
         d = 'x;
         resp = 2'bxx;
         return;
      end
      d    = axi.S_AXI_RDATA;
      resp = axi.S_AXI_RRESP;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      repeat (3) @(negedge clk);
      checks++;
      if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, axi.S_AXI_ARREADY,
           axi.S_AXI_RVALID, tbl_wr_req, tbl_rd_req} !== 7'b0) begin
         failures++;
         $display("FAIL reset_handshake got %b required 0000000", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY,
                  axi.S_AXI_BVALID, axi.S_AXI_ARREADY, axi.S_AXI_RVALID, tbl_wr_req, tbl_rd_req});
      end
      checks++;
      if ({axi.S_AXI_BRESP, axi.S_AXI_RRESP, tbl_wr_addr, tbl_wr_data} !== '0) begin
         failures++;
         $display("FAIL reset_values bresp=%b rresp=%b wr_addr=%h wr_data=%h required all 0",
                  axi.S_AXI_BRESP, axi.S_AXI_RRESP, tbl_wr_addr, tbl_wr_data);
      end
      reset = 1'b0;
      axi_read(32'h10, d, r);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin
         failures++;
         $display("FAIL reset_status got %h/%b required 0/00", d, r);
      end
      axi_read(32'h00, d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_wr_data got %h required 0", d); end
      axi_read(32'h0C, d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_rd_data got %h required 0", d); end
   endtask

   task automatic test_write_cmd();
      logic [31:0] d;
      logic [1:0]  r;
      int          base;
      base = wr_pulses;
      axi_write(32'h04, 32'd5, r);
      axi_write(32'h00, 32'h0A000001, r);
      axi_read(32'h04, d, r);
      checks++;
      if (d !== 32'd5) begin failures++; $display("FAIL addr_readback got %h required 5", d); end
      axi_read(32'h00, d, r);
      checks++;
      if (d !== 32'h0A000001) begin failures++; $display("FAIL wr_data_readback got %h required 0a000001", d); end
      axi_write(32'h08, 32'd1, r);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL wr_cmd_bresp got %b required 00", r); end
      checks++;
      if (req_after_hs !== 1'b1) begin failures++; $display("FAIL wr_cmd_latency req=%b required 1", req_after_hs); end
      repeat (4) @(negedge clk);
      checks++;
      if (wr_pulses - base !== 1 || seen_wr_addr !== 5'd5 || seen_wr_data !== 32'h0A000001) begin
         failures++;
         $display("FAIL wr_cmd_pulse pulses=%0d addr=%h data=%h required 1/05/0a000001",
                  wr_pulses - base, seen_wr_addr, seen_wr_data);
      end
      axi_read(32'h10, d, r);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL wr_cmd_status got %h required 2", d); end
   endtask

   task automatic test_read_cmd();
      logic [31:0] d;
      logic [1:0]  r;
      int          base;
      base = rd_pulses;
      resp_value = 32'h0A000001;
      axi_write(32'h08, 32'd2, r);
      checks++;
      if (req_after_hs !== 1'b1) begin failures++; $display("FAIL rd_cmd_latency req=%b required 1", req_after_hs); end
      repeat (4) @(negedge clk);
      checks++;
      if (rd_pulses - base !== 1 || seen_rd_addr !== 5'd5) begin
         failures++;
         $display("FAIL rd_cmd_pulse pulses=%0d addr=%h required 1/05", rd_pulses - base, seen_rd_addr);
      end
      axi_read(32'h0C, d, r);
      checks++;
      if (d !== 32'h0A000001) begin failures++; $display("FAIL rd_cmd_data got %h required 0a000001", d); end
      axi_read(32'h10, d, r);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL rd_cmd_status got %h required 2", d); end
   endtask

   task automatic test_timeout();
      logic [31:0] d;
      logic [1:0]  r;
      resp_en    = 1'b0;
      resp_value = 32'hFFFF_0000;
      axi_write(32'h08, 32'd2, r);
      axi_read(32'h10, d, r);
      checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL timeout_busy got %h required 1", d); end
      repeat (25) @(negedge clk);
      axi_read(32'h10, d, r);
      checks++;
      if (d !== 32'h6) begin failures++; $display("FAIL timeout_status got %h required 6", d); end
      axi_read(32'h0C, d, r);
      checks++;
      if (d !== 32'h0A000001) begin failures++; $display("FAIL timeout_rd_data got %h required 0a000001", d); end
      resp_en = 1'b1;
   endtask

   task automatic test_busy();
      logic [31:0] d;
      logic [1:0]  r;
      int          wb, rb;
      wb = wr_pulses;
      rb = rd_pulses;
      resp_delay = 10;
      axi_write(32'h08, 32'd1, r);
      checks++;
      if (r !== 2'b00) begin failures++; $display("FAIL busy_first_bresp got %b required 00", r); end
      axi_write(32'h08, 32'd2, r);
      checks++;
      if (r !== 2'b10) begin failures++; $display("FAIL busy_second_bresp got %b required 10", r); end
      axi_write(32'h00, 32'h12345678, r);
      checks++;
      if (r !== 2'b00 || tbl_wr_data !== 32'h0A000001) begin
         failures++;
         $display("FAIL busy_staging bresp=%b wr_data=%h required 00/0a000001", r, tbl_wr_data);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (wr_pulses - wb !== 1 || rd_pulses - rb !== 0) begin
         failures++;
         $display("FAIL busy_pulses wr=%0d rd=%0d required 1/0", wr_pulses - wb, rd_pulses - rb);
      end
      axi_read(32'h10, d, r);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL busy_status got %h required 2", d); end
      resp_delay = 1;
      axi_write(32'h08, 32'd3, r);
      repeat (4) @(negedge clk);
      checks++;
      if (r !== 2'b00 || wr_pulses - wb !== 1 || rd_pulses - rb !== 0) begin
         failures++;
         $display("FAIL bad_cmd bresp=%b wr=%0d rd=%0d required 00/1/0", r, wr_pulses - wb, rd_pulses - rb);
      end
      axi_write(32'h08, 32'd1, r);
      repeat (4) @(negedge clk);
      checks++;
      if (seen_wr_data !== 32'h12345678 || wr_pulses - wb !== 2) begin
         failures++;
         $display("FAIL deferred_wr_data data=%h pulses=%0d required 12345678/2", seen_wr_data, wr_pulses - wb);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      logic [1:0]  r;
      int          n;
      @(negedge clk);
      axi.S_AXI_AWADDR  = 32'h04;
      axi.S_AXI_WDATA   = 32'd7;
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_WVALID  = 1'b1;
      axi.S_AXI_BREADY  = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.S_AXI_BVALID && n < 20);
      axi.S_AXI_AWADDR = 32'h00;
      axi.S_AXI_WDATA  = 32'hDEADBEEF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (axi.S_AXI_BVALID !== 1'b1 || axi.S_AXI_BRESP !== 2'b00 || axi.S_AXI_AWREADY !== 1'b0) begin
            failures++;
            $display("FAIL b_hold cycle=%0d bvalid=%b bresp=%b awready=%b required 1/00/0",
                     i, axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_AWREADY);
         end
      end
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      axi.S_AXI_BREADY  = 1'b1;
      @(negedge clk);
      axi_read(32'h04, d, r);
      checks++;
      if (d !== 32'd7) begin failures++; $display("FAIL b_hold_addr got %h required 7", d); end
      axi_read(32'h00, d, r);
      checks++;
      if (d !== 32'h12345678) begin failures++; $display("FAIL b_hold_no_extra got %h required 12345678", d); end

      @(negedge clk);
      axi.S_AXI_ARADDR  = 32'h04;
      axi.S_AXI_ARVALID = 1'b1;
      axi.S_AXI_RREADY  = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.S_AXI_RVALID && n < 20);
      axi.S_AXI_ARADDR = 32'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (axi.S_AXI_RVALID !== 1'b1 || axi.S_AXI_RDATA !== 32'd7 || axi.S_AXI_ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL r_hold cycle=%0d rvalid=%b rdata=%h arready=%b required 1/00000007/0",
                     i, axi.S_AXI_RVALID, axi.S_AXI_RDATA, axi.S_AXI_ARREADY);
         end
      end
      axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_RREADY  = 1'b1;
      @(negedge clk);
      axi_read(32'h14, d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got %h required 0", d); end
      axi_read(32'h08, d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL cmd_read got %h required 0", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [1:0]  r;
      int          n;
      resp_en = 1'b0;
      @(negedge clk);
      axi.S_AXI_ARADDR  = 32'h10;
      axi.S_AXI_ARVALID = 1'b1;
      axi.S_AXI_RREADY  = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.S_AXI_RVALID && n < 20);
      axi.S_AXI_ARVALID = 1'b0;
      axi_write(32'h08, 32'd2, r);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({tbl_wr_req, tbl_rd_req, axi.S_AXI_BVALID, axi.S_AXI_RVALID,
           axi.S_AXI_AWREADY, axi.S_AXI_ARREADY} !== 6'b0) begin
         failures++;
         $display("FAIL mid_reset_outputs got %b required 000000", {tbl_wr_req, tbl_rd_req,
                  axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY, axi.S_AXI_ARREADY});
      end
      reset = 1'b0;
      axi.S_AXI_RREADY = 1'b1;
      axi_read(32'h10, d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL mid_reset_status got %h required 0", d); end
      axi_read(32'h04, d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL mid_reset_addr got %h required 0", d); end
      resp_en = 1'b1;
   endtask

   initial begin
      axi.S_AXI_AWADDR  = '0;
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WDATA   = '0;
      axi.S_AXI_WSTRB   = '1;
      axi.S_AXI_WVALID  = 1'b0;
      axi.S_AXI_BREADY  = 1'b1;
      axi.S_AXI_ARADDR  = '0;
      axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_RREADY  = 1'b1;
      req_after_hs      = 1'b0;
      test_reset();
      test_write_cmd();
      test_read_cmd();
      test_timeout();
      test_busy();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of sequence");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/dest_ip_tbl_ctrl.md
Name: dest_ip_tbl_ctrl

Overview:
AXI4-Lite register front end that initiates accesses to the destination-IP filter table over its req/ack table port (tbl_wr_req/tbl_rd_req/addr/data/ack). Software stages address/data, writes a command, then polls status. The block sequences a single-cycle request, waits for the responder's ack with a timeout, and captures read data. It sits between the output-port-lookup AXI-Lite slave and the dest-IP lookup stage.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI-Lite and table data width
C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width; only bits [4:2] decoded
TBL_ADDR_WIDTH, 5, table index width (32 entries)
ACK_TIMEOUT, 16, cycles to wait for ack after request before flagging timeout

Ports:
AXI_ACLK  in  1  clock
reset  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  ignored; full-word writes only
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response, always OKAY
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
tbl_wr_req  out  1  table write request pulse
tbl_rd_req  out  1  table read request pulse
tbl_wr_addr  out  TBL_ADDR_WIDTH  table write index
tbl_rd_addr  out  TBL_ADDR_WIDTH  table read index
tbl_wr_data  out  C_S_AXI_DATA_WIDTH  table write value
tbl_rd_data  in  C_S_AXI_DATA_WIDTH  table read value, valid with tbl_rd_ack
tbl_wr_ack  in  1  write ack
tbl_rd_ack  in  1  read ack

Behaviour:
- Register map (offset): 0x00 WR_DATA rw; 0x04 ADDR rw, bits [TBL_ADDR_WIDTH-1:0], rest read 0; 0x08 CMD wo (1=write, 2=read, other values ignored with OKAY; reads 0); 0x0C RD_DATA ro; 0x10 STATUS ro {29'b0, timeout, done, busy}; other offsets read 0, writes ignored.
- Reset: all AXI ready/valid outputs 0, BRESP/RRESP 0, all registers 0, tbl_* outputs 0, FSM IDLE.
- AXI write: AWREADY and WREADY asserted together for one cycle only when AWVALID & WVALID & !BVALID; BVALID next cycle, held until BREADY. BRESP OKAY, except CMD write while busy -> SLVERR (2'b10), command dropped.
- AXI read: ARREADY one cycle when ARVALID & !RVALID; RDATA/RVALID next cycle, held until RREADY. Read of STATUS does not clear it.
- FSM IDLE: accepted CMD=1 -> WR_REQ; CMD=2 -> RD_REQ; clears done/timeout, sets busy in same cycle.
- WR_REQ: tbl_wr_req=1 exactly one cycle, tbl_wr_addr=ADDR, tbl_wr_data=WR_DATA (both held stable until IDLE) -> WAIT_ACK.
- RD_REQ: tbl_rd_req=1 exactly one cycle, tbl_rd_addr=ADDR -> WAIT_ACK.
- WAIT_ACK: counter from 0; matching ack (wr_ack for write, rd_ack for read) -> latch tbl_rd_data into RD_DATA on read, done=1, busy=0, IDLE. Counter reaches ACK_TIMEOUT-1 without ack -> timeout=1, done=1, busy=0, RD_DATA unchanged, IDLE.
- Ack in same cycle as request (before WAIT_ACK) is ignored; acks in IDLE ignored; mismatched ack type ignored.
- Writes to WR_DATA/ADDR while busy are accepted but take effect only for the next command (outputs use values captured at command issue).
- Latency: CMD write handshake to req = 1 cycle; against the standard responder, req to ack = 1 cycle; done visible in STATUS on the next read thereafter.
- reset mid-transaction: FSM to IDLE, req deasserted immediately, pending AXI responses dropped.

Test Plan:
- Write ADDR=5, WR_DATA=0x0A000001, CMD=1; responder acks 1 cycle later -> one tbl_wr_req pulse with addr 5/data 0x0A000001, STATUS=0x2.
- Then ADDR=5, CMD=2, responder returns 0x0A000001 with rd_ack -> single tbl_rd_req pulse, RD_DATA=0x0A000001, STATUS=0x2.
- CMD=2 with ack never returned -> after ACK_TIMEOUT=16 cycles STATUS=0x6, RD_DATA keeps previous value.
- CMD=1 then CMD=2 issued while busy (responder delays ack 10 cycles) -> second BRESP=2'b10, only one tbl_wr_req pulse total.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data held stable, no new handshake accepted; read of 0x14 returns 0.
- Assert reset during WAIT_ACK -> next cycle tbl_*_req=0, STATUS=0, all AXI valids 0.
